// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } arb_state_e;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_e;

  localparam int unsigned TIMEOUT_CYC_DEFAULT = 64;

  // A lone requester wins outright; on a tie the port not granted last time wins.
  function automatic req_id_e arb_pick(logic ireq, logic dreq, req_id_e last);
    if (ireq && dreq) begin
      return (last == REQ_I) ? REQ_D : REQ_I;
    end else if (ireq) begin
      return REQ_I;
    end else begin
      return REQ_D;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between an icache-refill port and a data port onto a single
// memory channel, with a per-transaction timeout that completes the access with an error.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy,
  input  logic        mem_valid
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  arb_state_e  r_state;
  req_id_e     r_win;
  req_id_e     r_last_grant;
  logic [CntW-1:0] r_cnt;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        r_i_ack;
  logic [31:0] r_i_rdata;
  logic        r_i_err;
  logic        r_d_ack;
  logic [31:0] r_d_rdata;
  logic        r_d_err;

  req_id_e     w_grant;
  logic        w_timeout;
  logic        w_done;
  logic [31:0] w_rsp_data;
  logic        w_rsp_err;

  always_comb begin
    w_grant    = arb_pick(i_req, d_req, r_last_grant);
    w_timeout  = (r_cnt == CntW'(TIMEOUT_CYC - 1));
    w_done     = mem_valid || w_timeout;
    // A completion strobe always beats a coincident timeout.
    w_rsp_data = mem_valid ? mem_rdata : 32'h0;
    w_rsp_err  = !mem_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_win        <= REQ_I;
      r_last_grant <= REQ_D;
      r_cnt        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_i_ack      <= 1'b0;
      r_i_rdata    <= 32'h0;
      r_i_err      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_d_rdata    <= 32'h0;
      r_d_err      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if ((i_req || d_req) && !mem_busy) begin
            r_win     <= w_grant;
            r_mem_req <= 1'b1;
            r_cnt     <= '0;
            r_state   <= WAIT;
            if (w_grant == REQ_I) begin
              r_mem_we    <= 1'b0;
              r_mem_addr  <= i_addr;
              r_mem_wdata <= 32'h0;
            end else begin
              r_mem_we    <= d_we;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
            end
          end
        end

        WAIT: begin
          if (w_done) begin
            r_mem_req <= 1'b0;
            r_state   <= RESP;
            if (r_win == REQ_I) begin
              r_i_ack   <= 1'b1;
              r_i_rdata <= w_rsp_data;
              r_i_err   <= w_rsp_err;
            end else begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= w_rsp_data;
              r_d_err   <= w_rsp_err;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        RESP: begin
          r_i_ack      <= 1'b0;
          r_i_rdata    <= 32'h0;
          r_i_err      <= 1'b0;
          r_d_ack      <= 1'b0;
          r_d_rdata    <= 32'h0;
          r_d_err      <= 1'b0;
          r_last_grant <= r_win;
          r_cnt        <= '0;
          r_state      <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  assign i_ack     = r_i_ack;
  assign i_rdata   = r_i_rdata;
  assign i_err     = r_i_err;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;

endmodule
